// File: rtl/draw_board_if.sv
// VGA timing stream: counters, syncs, blanking and colour for one pixel.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in (
        input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

    modport out (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );
endinterface

// File: rtl/draw_board.sv
// Battleship-style board overlay: grid, cell status colours, blinking hits
// and a frame-latched cursor drawn on top of a VGA timing stream.
module draw_board #(
    parameter int X_POS        = 0,
    parameter int Y_POS        = 0,
    parameter int COLS         = 12,
    parameter int ROWS         = 12,
    parameter int CELL_LOG2    = 5,
    parameter int BORDER       = 2,
    parameter int MEM_LAT      = 1,
    parameter int BLINK_FRAMES = 16,
    localparam int COL_W       = $clog2(COLS),
    localparam int ROW_W       = $clog2(ROWS),
    localparam int ADDR_W      = COL_W + ROW_W
) (
    input  logic              clk,
    input  logic              rst,
    vga_if.in                 in,
    input  logic [1:0]        cell_status,
    input  logic [COL_W-1:0]  cursor_col,
    input  logic [ROW_W-1:0]  cursor_row,
    input  logic              cursor_en,
    input  logic              blink_en,
    output logic [ADDR_W-1:0] cell_addr,
    vga_if.out                out
);
    localparam int CELL = 1 << CELL_LOG2;
    localparam logic [11:0] X_LO = 12'(X_POS);
    localparam logic [11:0] X_HI = 12'(X_POS + COLS * CELL);
    localparam logic [11:0] Y_LO = 12'(Y_POS);
    localparam logic [11:0] Y_HI = 12'(Y_POS + ROWS * CELL);
    localparam logic [10:0] X_OFS = 11'(X_POS);
    localparam logic [10:0] Y_OFS = 11'(Y_POS);
    localparam logic [CELL_LOG2-1:0] B_IN = CELL_LOG2'(BORDER);
    localparam logic [CELL_LOG2-1:0] B_RING = CELL_LOG2'(BORDER + 2);
    localparam logic [CELL_LOG2-1:0] B_FAR = CELL_LOG2'(CELL - 2);
    localparam logic [COL_W:0] COL_LIM = (COL_W + 1)'(COLS);
    localparam logic [ROW_W:0] ROW_LIM = (ROW_W + 1)'(ROWS);
    localparam logic [7:0] F_LAST = 8'(BLINK_FRAMES - 1);

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } px_t;

    function automatic logic in_span(
        input logic [10:0] v,
        input logic [11:0] lo,
        input logic [11:0] hi
    );
        return ({1'b0, v} >= lo) && ({1'b0, v} < hi);
    endfunction

    px_t cur_px;
    px_t pix;
    px_t out_r;
    px_t dly [MEM_LAT+1];

    logic             vsync_q;
    logic             frame_ev;
    logic             cur_en;
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;
    logic             cur_ok;
    logic [7:0]       frame_cnt;
    logic             phase;

    logic             in_board;
    logic [COL_W-1:0] in_col;
    logic [ROW_W-1:0] in_row;

    logic                 pix_board;
    logic [COL_W-1:0]     pix_col;
    logic [ROW_W-1:0]     pix_row;
    logic [CELL_LOG2-1:0] lx;
    logic [CELL_LOG2-1:0] ly;
    logic                 interior;
    logic                 ring;
    logic [11:0]          rgb_next;

    assign cur_px = {in.hcount, in.vcount, in.hsync, in.vsync,
                     in.hblnk, in.vblnk, in.rgb};
    assign pix = dly[MEM_LAT];
    assign frame_ev = in.vsync && !vsync_q;
    assign cur_ok = cur_en && ({1'b0, cur_col} < COL_LIM)
                           && ({1'b0, cur_row} < ROW_LIM);

    assign out.hcount = out_r.hcount;
    assign out.vcount = out_r.vcount;
    assign out.hsync  = out_r.hsync;
    assign out.vsync  = out_r.vsync;
    assign out.hblnk  = out_r.hblnk;
    assign out.vblnk  = out_r.vblnk;
    assign out.rgb    = out_r.rgb;

    always_comb begin
        in_board = in_span(in.hcount, X_LO, X_HI)
                && in_span(in.vcount, Y_LO, Y_HI);
        in_col = COL_W'((in.hcount - X_OFS) >> CELL_LOG2);
        in_row = ROW_W'((in.vcount - Y_OFS) >> CELL_LOG2);
    end

    // Colour is decided on the delayed pixel, aligned with cell_status.
    always_comb begin
        pix_board = in_span(pix.hcount, X_LO, X_HI)
                 && in_span(pix.vcount, Y_LO, Y_HI);
        pix_col = COL_W'((pix.hcount - X_OFS) >> CELL_LOG2);
        pix_row = ROW_W'((pix.vcount - Y_OFS) >> CELL_LOG2);
        lx = CELL_LOG2'(pix.hcount - X_OFS);
        ly = CELL_LOG2'(pix.vcount - Y_OFS);
        interior = pix_board && (lx >= B_IN) && (ly >= B_IN);
        ring = (lx < B_RING) || (ly < B_RING)
            || (lx >= B_FAR) || (ly >= B_FAR);
        rgb_next = pix.rgb;
        if (interior && !pix.hblnk && !pix.vblnk) begin
            unique case (cell_status)
                2'b00:   rgb_next = 12'hFFF;
                2'b01:   rgb_next = 12'h0F0;
                2'b10:   rgb_next = 12'h00F;
                default: rgb_next = (blink_en && phase) ? 12'hF80 : 12'hF00;
            endcase
            if (cur_ok && ring && cur_col == pix_col && cur_row == pix_row)
                rgb_next = 12'hFF0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cell_addr <= '0;
            vsync_q   <= 1'b0;
            cur_en    <= 1'b0;
            cur_col   <= '0;
            cur_row   <= '0;
            frame_cnt <= '0;
            phase     <= 1'b0;
            out_r     <= '0;
            for (int i = 0; i <= MEM_LAT; i++)
                dly[i] <= '0;
        end else begin
            cell_addr <= in_board ? {in_col, in_row} : '0;
            vsync_q   <= in.vsync;
            if (frame_ev) begin
                cur_en  <= cursor_en;
                cur_col <= cursor_col;
                cur_row <= cursor_row;
                if (frame_cnt == F_LAST) begin
                    frame_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
            dly[0] <= cur_px;
            for (int i = 1; i <= MEM_LAT; i++)
                dly[i] <= dly[i-1];
            out_r <= {pix.hcount, pix.vcount, pix.hsync, pix.vsync,
                      pix.hblnk, pix.vblnk, rgb_next};
        end
    end
endmodule

// File: tb/tb_draw_board.sv
// Scoreboard bench for draw_board: driver pushes model predictions,
// a monitor pops and compares them when they fall due.
module tb_draw_board;
    localparam int X_POS = 0;
    localparam int Y_POS = 0;
    localparam int COLS = 12;
    localparam int ROWS = 12;
    localparam int CELL_LOG2 = 5;
    localparam int CELL = 32;
    localparam int BORDER = 2;
    localparam int MEM_LAT = 1;
    localparam int BLINK_FRAMES = 2;
    localparam int COL_W = 4;
    localparam int ROW_W = 4;
    localparam int ADDR_W = 8;
    localparam int LAT = MEM_LAT + 2;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } px_t;

    typedef struct { int due; px_t v; } out_e;
    typedef struct { int due; logic [ADDR_W-1:0] a; } addr_e;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0] cell_status;
    logic [COL_W-1:0] cursor_col = '0;
    logic [ROW_W-1:0] cursor_row = '0;
    logic cursor_en = 1'b0;
    logic blink_en = 1'b0;
    logic [ADDR_W-1:0] cell_addr;

    vga_if vin ();
    vga_if vout ();

    draw_board #(
        .X_POS(X_POS), .Y_POS(Y_POS), .COLS(COLS), .ROWS(ROWS),
        .CELL_LOG2(CELL_LOG2), .BORDER(BORDER), .MEM_LAT(MEM_LAT),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk), .rst(rst), .in(vin), .cell_status(cell_status),
        .cursor_col(cursor_col), .cursor_row(cursor_row),
        .cursor_en(cursor_en), .blink_en(blink_en),
        .cell_addr(cell_addr), .out(vout)
    );

    always #5 clk = ~clk;

    // Status memory: contents fixed, read data appears MEM_LAT clocks later.
    logic [1:0] mem [1 << ADDR_W];
    logic [1:0] mp [MEM_LAT];
    always @(posedge clk) begin
        mp[0] <= mem[cell_addr];
        for (int i = 1; i < MEM_LAT; i++)
            mp[i] <= mp[i-1];
    end
    assign cell_status = mp[MEM_LAT-1];

    out_e  oq[$];
    addr_e aq[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    int frames = 0;
    bit prev_vs = 0;
    bit lc_en = 0;
    int lc_col = 0;
    int lc_row = 0;

    function automatic bit on_board(int h, int v);
        return h >= X_POS && h < X_POS + COLS * CELL
            && v >= Y_POS && v < Y_POS + ROWS * CELL;
    endfunction

    function automatic logic [ADDR_W-1:0] exp_addr(int h, int v);
        int rx = (h - X_POS) & 2047;
        int ry = (v - Y_POS) & 2047;
        if (!on_board(h, v)) return '0;
        return ADDR_W'((rx / CELL) * (1 << ROW_W) + ry / CELL);
    endfunction

    function automatic px_t exp_out(px_t p);
        px_t r = p;
        int h = int'(p.hcount);
        int v = int'(p.vcount);
        int rx = (h - X_POS) & 2047;
        int ry = (v - Y_POS) & 2047;
        int col = rx / CELL;
        int row = ry / CELL;
        int lx = rx % CELL;
        int ly = ry % CELL;
        bit ph = ((frames / BLINK_FRAMES) % 2) == 1;
        bit edge_px = lx < BORDER + 2 || ly < BORDER + 2
                   || lx >= CELL - 2 || ly >= CELL - 2;
        if (on_board(h, v) && !p.hblnk && !p.vblnk
            && lx >= BORDER && ly >= BORDER) begin
            case (mem[col * (1 << ROW_W) + row])
                2'd0: r.rgb = 12'hFFF;
                2'd1: r.rgb = 12'h0F0;
                2'd2: r.rgb = 12'h00F;
                default: r.rgb = (blink_en && ph) ? 12'hF80 : 12'hF00;
            endcase
            if (lc_en && lc_col < COLS && lc_row < ROWS
                && lc_col == col && lc_row == row && edge_px)
                r.rgb = 12'hFF0;
        end
        return r;
    endfunction

    task automatic px(input int h, input int v,
                      input bit hb, input bit vb, input bit vs);
        px_t p;
        @(negedge clk);
        rst = 1'b0;
        p.hcount = 11'(h);
        p.vcount = 11'(v);
        p.hsync = 1'($urandom);
        p.vsync = vs;
        p.hblnk = hb;
        p.vblnk = vb;
        p.rgb = 12'($urandom);
        vin.hcount = p.hcount;
        vin.vcount = p.vcount;
        vin.hsync = p.hsync;
        vin.vsync = p.vsync;
        vin.hblnk = p.hblnk;
        vin.vblnk = p.vblnk;
        vin.rgb = p.rgb;
        if (vs && !prev_vs) begin
            frames++;
            lc_en = cursor_en;
            lc_col = int'(cursor_col);
            lc_row = int'(cursor_row);
        end
        prev_vs = vs;
        aq.push_back('{cyc + 1, exp_addr(int'(p.hcount), int'(p.vcount))});
        oq.push_back('{cyc + LAT, exp_out(p)});
    endtask

    task automatic dpx(input int h, input int v);
        px(h, v, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic blanks(input int n, input bit vs);
        for (int i = 0; i < n; i++)
            px($urandom % 448, $urandom % 448, 1'b1, 1'b1, vs);
    endtask

    task automatic new_frame(input bit be);
        blanks(LAT + 1, 1'b0);
        blink_en = be;
        blanks(LAT + 1, 1'b1);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1;
            while (aq.size() > 0 && aq[$].due > cyc) void'(aq.pop_back());
            while (oq.size() > 0 && oq[$].due > cyc) void'(oq.pop_back());
            aq.push_back('{cyc + 1, '0});
            oq.push_back('{cyc + 1, '0});
        end
        frames = 0;
        prev_vs = 0;
        lc_en = 0;
        lc_col = 0;
        lc_row = 0;
    endtask

    function automatic int rnd_coord();
        int e[10] = '{0, 1, 2, 31, 32, 33, 383, 384, 385, 2047};
        if ($urandom % 6 == 0) return e[$urandom % 10];
        return $urandom % 448;
    endfunction

    initial begin
        out_e oe;
        addr_e ae;
        px_t got;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (aq.size() > 0 && aq[0].due <= cyc) begin
                ae = aq.pop_front();
                checks++;
                if (cell_addr !== ae.a || ae.due != cyc) begin
                    errors++;
                    $display("FAIL cell_addr cyc=%0d got=%h want=%h",
                             cyc, cell_addr, ae.a);
                end
            end
            while (oq.size() > 0 && oq[0].due <= cyc) begin
                oe = oq.pop_front();
                got = {vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                       vout.hblnk, vout.vblnk, vout.rgb};
                checks++;
                if (got !== oe.v || oe.due != cyc) begin
                    errors++;
                    $display("FAIL out cyc=%0d got h=%0d v=%0d s=%b%b b=%b%b rgb=%h want h=%0d v=%0d s=%b%b b=%b%b rgb=%h",
                             cyc, got.hcount, got.vcount, got.hsync,
                             got.vsync, got.hblnk, got.vblnk, got.rgb,
                             oe.v.hcount, oe.v.vcount, oe.v.hsync,
                             oe.v.vsync, oe.v.hblnk, oe.v.vblnk, oe.v.rgb);
                end
            end
        end
    end

    initial begin
        int cut;
        int h;
        int v;
        vin.hcount = '0;
        vin.vcount = '0;
        vin.hsync = 1'b0;
        vin.vsync = 1'b0;
        vin.hblnk = 1'b0;
        vin.vblnk = 1'b0;
        vin.rgb = '0;
        for (int i = 0; i < (1 << ADDR_W); i++)
            mem[i] = 2'($urandom);
        mem[8'h11] = 2'b01;
        mem[8'h34] = 2'b10;
        mem[8'h55] = 2'b11;

        do_reset(3);

        new_frame(1'b0);
        dpx(33, 66);
        dpx(40, 40);
        dpx(2047, 40);
        dpx(384, 40);
        dpx(40, 384);
        dpx(383, 383);
        cursor_col = 4'd3;
        cursor_row = 4'd4;
        cursor_en = 1'b1;
        dpx(98, 138);
        dpx(106, 138);

        new_frame(1'b0);
        dpx(98, 138);
        dpx(106, 138);
        dpx(98, 130);
        dpx(100, 100);
        do_reset(1);
        dpx(98, 138);
        dpx(106, 138);
        dpx(170, 170);

        for (int f = 0; f < 5; f++) begin
            new_frame(1'b1);
            dpx(170, 170);
            dpx(100, 140);
        end
        for (int f = 0; f < 3; f++) begin
            new_frame(1'b0);
            dpx(170, 170);
        end

        for (int f = 0; f < 40; f++) begin
            new_frame(1'($urandom));
            cut = $urandom % 50;
            for (int k = 0; k < 60; k++) begin
                if (k == cut && $urandom % 2 == 1) begin
                    cursor_col = 4'($urandom);
                    cursor_row = 4'($urandom);
                    cursor_en = 1'($urandom);
                end
                if (k == cut + 5 && f % 10 == 7)
                    do_reset(1);
                if ($urandom % 4 == 0 && lc_en
                    && lc_col < COLS && lc_row < ROWS) begin
                    h = X_POS + lc_col * CELL + $urandom % CELL;
                    v = Y_POS + lc_row * CELL + $urandom % CELL;
                end else begin
                    h = rnd_coord();
                    v = rnd_coord();
                end
                px(h, v, $urandom % 8 == 0, $urandom % 16 == 0, 1'b0);
            end
        end

        repeat (LAT + 2) @(negedge clk);
        checks++;
        if (aq.size() != 0 || oq.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d/%0d pending want=0/0",
                     aq.size(), oq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
